// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures the high time of an incoming servo/RC PWM
// signal in prescaled ticks, reports accepted widths on cntout with a
// one-cycle strobe, rejects out-of-range pulses and flags loss of signal.
// CNT_W must satisfy MAX_CNT < 2**CNT_W - 1 so that both the largest accepted
// width and the saturated MAX_CNT+1 value fit in the width register.
module servo_pwm_capture #(
  parameter int CLK_DIV    = 240,
  parameter int CNT_W      = 8,
  parameter int MIN_CNT    = 25,
  parameter int MAX_CNT    = 150,
  parameter int RESET_CNT  = 85,
  parameter int LOST_TICKS = 2500
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             pwmin,
  output logic [CNT_W-1:0] cntout,
  output logic             cnt_valid,
  output logic             err_pulse,
  output logic             lost
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LOST_W = $clog2(LOST_TICKS + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  WIDTH_SAT = CNT_W'(MAX_CNT + 1);
  localparam logic [CNT_W-1:0]  WIDTH_MIN = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0]  WIDTH_MAX = CNT_W'(MAX_CNT);
  localparam logic [LOST_W-1:0] LOST_SAT  = LOST_W'(LOST_TICKS);
  localparam logic [LOST_W-1:0] LOST_PRE  = LOST_W'(LOST_TICKS - 1);

  typedef enum logic [1:0] {
    S_SYNC,
    S_LOW,
    S_HIGH
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               rise;
  logic               fall;
  logic               tick;
  logic [PRE_W-1:0]   prescaler;
  logic [CNT_W-1:0]   width;
  logic [CNT_W-1:0]   width_eval;
  logic [LOST_W-1:0]  lost_timer;
  logic               lost_hit;
  logic               width_clear;
  logic               width_inc;
  logic               accept;
  logic               reject;

  // Synchronizer plus edge-detect delay; deliberately not reset so that a
  // pulse already in progress at reset is seen as high and skipped by S_SYNC.
  always_ff @(posedge clkin) begin
    s1 <= pwmin;
    s2 <= s1;
    s3 <= s2;
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign tick = (prescaler == PRE_LAST);

  // A tick landing in the fall cycle still counts toward the evaluated width.
  assign width_eval = (tick && (width != WIDTH_SAT)) ? width + 1'b1 : width;
  assign lost_hit   = !rise && tick && (lost_timer == LOST_PRE);

  // Prescaler: free-running tick divider, re-phased on every rising edge.
  always_ff @(posedge clkin) begin
    if (rst) begin
      prescaler <= '0;
    end else if (rise || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state <= S_SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_SYNC:  if (!s2) state_next = S_LOW;
      S_LOW:   if (rise) state_next = S_HIGH;
      S_HIGH:  if (fall) state_next = S_LOW;
      default: state_next = S_SYNC;
    endcase
  end

  // Output decode: width control and accept/reject decision on the fall.
  always_comb begin
    width_clear = 1'b0;
    width_inc   = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    case (state)
      S_LOW: width_clear = rise;
      S_HIGH: begin
        if (fall) begin
          if ((width_eval >= WIDTH_MIN) && (width_eval <= WIDTH_MAX)) begin
            accept = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end else begin
          width_inc = tick && (width != WIDTH_SAT);
        end
      end
      default: ;
    endcase
  end

  // Width counter in ticks, saturating at MAX_CNT+1.
  always_ff @(posedge clkin) begin
    if (rst) begin
      width <= '0;
    end else if (width_clear) begin
      width <= '0;
    end else if (width_inc) begin
      width <= width + 1'b1;
    end
  end

  // Lost timer: ticks since the last rising edge, saturating.
  always_ff @(posedge clkin) begin
    if (rst) begin
      lost_timer <= '0;
    end else if (rise) begin
      lost_timer <= '0;
    end else if (tick && (lost_timer != LOST_SAT)) begin
      lost_timer <= lost_timer + 1'b1;
    end
  end

  // Registered outputs: strobes, accepted width and lost flag.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cntout    <= CNT_W'(RESET_CNT);
      cnt_valid <= 1'b0;
      err_pulse <= 1'b0;
      lost      <= 1'b1;
    end else begin
      cnt_valid <= accept;
      err_pulse <= reject;
      if (accept) begin
        cntout <= width_eval;
        lost   <= 1'b0;
      end else if (lost_hit) begin
        lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb_servo_pwm_capture: random and directed PWM pulses; a reference model
// predicts each strobe from pulse length alone and a monitor checks it.
module tb_servo_pwm_capture;

  localparam int D         = 8;
  localparam int CNT_W     = 8;
  localparam int MIN_CNT   = 25;
  localparam int MAX_CNT   = 150;
  localparam int RESET_CNT = 85;
  localparam int LOST      = 2500;

  typedef struct {
    bit     is_err;
    int     cnt;
    bit     lst;
    longint cyc;
  } exp_t;

  logic             clkin = 1'b0;
  logic             rst = 1'b1;
  logic             pwmin = 1'b0;
  logic [CNT_W-1:0] cntout;
  logic             cnt_valid;
  logic             err_pulse;
  logic             lost;

  exp_t   sb[$];
  longint cycle_count = 0;
  longint last_rise = 0;
  int     total = 0;
  int     bad = 0;
  int     model_cnt = RESET_CNT;
  bit     model_lost = 1'b1;

  servo_pwm_capture #(
    .CLK_DIV(D), .CNT_W(CNT_W), .MIN_CNT(MIN_CNT), .MAX_CNT(MAX_CNT),
    .RESET_CNT(RESET_CNT), .LOST_TICKS(LOST)
  ) dut (
    .clkin(clkin), .rst(rst), .pwmin(pwmin), .cntout(cntout),
    .cnt_valid(cnt_valid), .err_pulse(err_pulse), .lost(lost)
  );

  // Clock generation.
  always #5 clkin = ~clkin;

  // Cycle counter used to time expected strobes.
  always @(posedge clkin) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle_count);
    end
  endtask

  // Reference model: a pulse of H clock cycles measures floor(H/D) ticks.
  task automatic predict(input int high_cycles, input longint drop_cyc);
    exp_t e;
    int   w;
    w = high_cycles / D;
    e.cyc = drop_cyc + 3;
    if (w >= MIN_CNT && w <= MAX_CNT) begin
      model_cnt  = w;
      model_lost = 1'b0;
      e.is_err = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.cnt = model_cnt;
    e.lst = model_lost;
    sb.push_back(e);
  endtask

  // Drive one pulse of high_cycles, then low for low_cycles.
  task automatic applyStimulus(input int high_cycles, input int low_cycles, input bit measured);
    @(negedge clkin);
    pwmin = 1'b1;
    last_rise = cycle_count;
    repeat (high_cycles) @(negedge clkin);
    pwmin = 1'b0;
    if (measured) predict(high_cycles, cycle_count);
    repeat (low_cycles) @(negedge clkin);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cntout"}, cntout, RESET_CNT);
    checkOutput({tag, "_lost"}, lost, 1);
    checkOutput({tag, "_cnt_valid"}, cnt_valid, 0);
    checkOutput({tag, "_err_pulse"}, err_pulse, 0);
  endtask

  task automatic doReset(input logic pin_level);
    @(negedge clkin);
    pwmin = pin_level;
    rst = 1'b1;
    repeat (4) @(negedge clkin);
    checkReset("reset");
    rst = 1'b0;
    model_cnt  = RESET_CNT;
    model_lost = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every strobe and flags missed strobes.
  always @(negedge clkin) begin
    exp_t e;
    if (sb.size() > 0 && cycle_count > sb[0].cyc) begin
      e = sb.pop_front();
      checkOutput("missed_strobe", 0, e.cyc);
    end
    if (cnt_valid || err_pulse) begin
      if (cnt_valid && err_pulse) begin
        checkOutput("strobe_exclusive", 1, 0);
      end else if (sb.size() == 0) begin
        checkOutput("unexpected_strobe", cycle_count, -1);
      end else begin
        e = sb.pop_front();
        checkOutput("strobe_kind_err", err_pulse, e.is_err);
        checkOutput("strobe_cycle", cycle_count, e.cyc);
        checkOutput("cntout", cntout, e.cnt);
        checkOutput("lost_at_strobe", lost, e.lst);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int k;
    int h;
    longint target;

    doReset(1'b0);
    repeat (10) @(negedge clkin);

    // Directed boundary pulses.
    applyStimulus(135 * D, 20, 1'b1);
    checkOutput("lost_after_valid", lost, 0);
    applyStimulus(35 * D + D - 1, 20, 1'b1);
    applyStimulus(35 * D, 20, 1'b1);
    applyStimulus(24 * D, 20, 1'b1);
    applyStimulus(151 * D, 20, 1'b1);
    applyStimulus(24 * D + D - 1, 20, 1'b1);
    applyStimulus(25 * D, 20, 1'b1);
    applyStimulus(150 * D + D - 1, 20, 1'b1);
    applyStimulus(200 * D, 20, 1'b1);

    // Randomized pulses.
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(156, 20);
      h = k * D + $urandom_range(D - 1, 0);
      applyStimulus(h, $urandom_range(60, 6), 1'b1);
    end

    // Pin high through reset release: first fall must be ignored.
    doReset(1'b1);
    repeat (3000) @(negedge clkin);
    pwmin = 1'b0;
    repeat (20) @(negedge clkin);
    checkOutput("sync_lost_still_set", lost, 1);
    applyStimulus(100 * D, 20, 1'b1);

    // Lost boundary: held low after the last rise.
    applyStimulus(60 * D, 20, 1'b1);
    target = last_rise + 2 + longint'(LOST) * D;
    while (cycle_count < target) @(negedge clkin);
    checkOutput("lost_before_boundary", lost, 0);
    @(negedge clkin);
    checkOutput("lost_at_boundary", lost, 1);
    model_lost = 1'b1;
    applyStimulus(80 * D, 20, 1'b1);
    checkOutput("lost_cleared", lost, 0);

    // Reset in the middle of a pulse abandons it.
    @(negedge clkin);
    pwmin = 1'b1;
    repeat (50 * D) @(negedge clkin);
    rst = 1'b1;
    @(negedge clkin);
    checkReset("midpulse");
    rst = 1'b0;
    model_cnt  = RESET_CNT;
    model_lost = 1'b1;
    repeat (50 * D) @(negedge clkin);
    pwmin = 1'b0;
    repeat (30) @(negedge clkin);
    checkOutput("midpulse_cntout_kept", cntout, RESET_CNT);
    applyStimulus(90 * D, 20, 1'b1);

    repeat (20) @(negedge clkin);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
